// File: rtl/instr_encode_loader.sv
// Boot-time program loader: encodes symbolic RV64 instructions and
// writes them sequentially into instruction memory while holding the core.
module instr_encode_loader #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_kind,
    input  logic [4:0]        op_rd,
    input  logic [4:0]        op_rs1,
    input  logic [4:0]        op_rs2,
    input  logic [12:0]       op_imm,
    input  logic              op_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-2:0] count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic        last_q;
    logic [31:0] enc;
    logic        bad_op;
    logic        bad_imm;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;

    always_comb begin
        r_f3 = 3'b000;
        r_f7 = 7'b0000000;
        if (op_kind == 3'd1) r_f7 = 7'b0100000;
        if (op_kind == 3'd2) r_f3 = 3'b111;
        if (op_kind == 3'd3) r_f3 = 3'b110;
    end

    // Immediate range for ld/sd is 12-bit signed; beq offsets must be even.
    always_comb begin
        enc     = 32'h0;
        bad_op  = 1'b0;
        bad_imm = 1'b0;
        case (op_kind)
            3'd0, 3'd1, 3'd2, 3'd3:
                enc = {r_f7, op_rs2, op_rs1, r_f3, op_rd, 7'b0110011};
            3'd4: begin
                enc = {op_imm[11:0], op_rs1, 3'b011, op_rd, 7'b0000011};
                bad_imm = op_imm[12] ^ op_imm[11];
            end
            3'd5: begin
                enc = {op_imm[11:5], op_rs2, op_rs1, 3'b011,
                       op_imm[4:0], 7'b0100011};
                bad_imm = op_imm[12] ^ op_imm[11];
            end
            3'd6: begin
                enc = {op_imm[12], op_imm[10:5], op_rs2, op_rs1, 3'b000,
                       op_imm[4:1], op_imm[11], 7'b1100011};
                bad_imm = op_imm[0];
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= BASE;
            mem_wdata <= 32'h0;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            last_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= ACCEPT;
                        mem_addr <= BASE;
                        count    <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= 2'b00;
                    end
                end
                ACCEPT: begin
                    if (op_valid) begin
                        if (bad_op) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else if (bad_imm) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= 2'b10;
                        end else begin
                            state     <= WRITE;
                            mem_wdata <= enc;
                            last_q    <= op_last;
                        end
                    end
                end
                WRITE: begin
                    count <= count + 1'b1;
                    // The top word is the last slot; the address never wraps.
                    if (mem_addr != TOP) mem_addr <= mem_addr + ADDR_W'(4);
                    if (last_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (mem_addr == TOP) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                    end else begin
                        state <= ACCEPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign op_ready = (state == ACCEPT);
    assign mem_we   = (state == WRITE);
    assign busy     = (state == ACCEPT) || (state == WRITE);
    assign cpu_hold = busy || (state == ERR);

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encode table, handshake,
// error, overflow and reset-in-write sequences.
module tb_instr_encode_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, s_reset, s_start;
    logic        op_valid, op_last;
    logic [2:0]  op_kind;
    logic [4:0]  op_rd, op_rs1, op_rs2;
    logic [12:0] op_imm;

    logic        op_ready, mem_we, cpu_hold, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  count;

    logic        s_op_ready, s_mem_we, s_cpu_hold, s_busy, s_done, s_err;
    logic [3:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [1:0]  s_err_code;
    logic [2:0]  s_count;

    instr_encode_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_kind(op_kind), .op_rd(op_rd), .op_rs1(op_rs1),
        .op_rs2(op_rs2), .op_imm(op_imm), .op_last(op_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .count(count)
    );

    instr_encode_loader #(.ADDR_W(4)) dut_s (
        .clk(clk), .reset(s_reset), .start(s_start),
        .op_valid(op_valid), .op_ready(s_op_ready),
        .op_kind(op_kind), .op_rd(op_rd), .op_rs1(op_rs1),
        .op_rs2(op_rs2), .op_imm(op_imm), .op_last(op_last),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .cpu_hold(s_cpu_hold),
        .busy(s_busy), .done(s_done), .err(s_err),
        .err_code(s_err_code), .count(s_count)
    );

    typedef struct {
        logic [2:0]  k;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    // Memory-side write log, captured at the edge the memory would write.
    logic [9:0]  log_a[$];
    logic [31:0] log_d[$];
    logic [3:0]  slog_a[$];
    logic [31:0] slog_d[$];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
        end
        if (s_mem_we === 1'b1) begin
            slog_a.push_back(s_mem_addr);
            slog_d.push_back(s_mem_wdata);
        end
    end

    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(input logic [2:0] k, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [12:0] imm, input logic last,
                                input logic [31:0] exp);
        vec_t v;
        v.k = k; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.last = last; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        op_kind  = v.k;
        op_rd    = v.rd;
        op_rs1   = v.rs1;
        op_rs2   = v.rs2;
        op_imm   = v.imm;
        op_last  = v.last;
        op_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input vec_t v, input bit sm, output int w);
        drive(v);
        w = 0;
        while (!(sm ? s_op_ready : op_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", sm ? s_op_ready : op_ready, 1);
        @(negedge clk);
    endtask

    task automatic pulse(input bit sm);
        if (sm) s_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        start   = 1'b0;
    endtask

    vec_t mix[5];
    vec_t ev[3];
    logic [1:0] ecode[3];
    vec_t tmp;
    int   w;
    int   n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mix[0] = mk(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3);
        mix[1] = mk(3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0, 32'h407302B3);
        mix[2] = mk(3'd4, 5'd10, 5'd2, 5'd9, 13'd8, 1'b0, 32'h00813503);
        mix[3] = mk(3'd5, 5'd17, 5'd2, 5'd5, 13'h1FFC, 1'b0, 32'hFE513E23);
        mix[4] = mk(3'd6, 5'd31, 5'd1, 5'd2, 13'h1FF8, 1'b1, 32'hFE208CE3);
        ev[0] = mk(3'd7, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 32'h0);
        ev[1] = mk(3'd4, 5'd1, 5'd2, 5'd0, 13'h0800, 1'b0, 32'h0);
        ev[2] = mk(3'd6, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 32'h0);
        ecode[0] = 2'b01;
        ecode[1] = 2'b10;
        ecode[2] = 2'b10;

        reset = 1'b1; s_reset = 1'b1;
        start = 1'b0; s_start = 1'b0;
        op_valid = 1'b0; op_last = 1'b0; op_kind = 3'd0;
        op_rd = 5'd0; op_rs1 = 5'd0; op_rs2 = 5'd0; op_imm = 13'd0;
        repeat (3) @(negedge clk);

        chk("rst_addr", mem_addr, 0);
        chk("rst_ready", op_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_count", count, 0);
        reset = 1'b0; s_reset = 1'b0;
        @(negedge clk);

        // Encode mix, valid held high back to back
        pulse(0);
        chk("acc_ready", op_ready, 1);
        chk("acc_hold", {cpu_hold, busy}, 2'b11);
        n = log_a.size();
        for (int i = 0; i < 5; i++) begin
            send(mix[i], 0, w);
            chk("hs_we", mem_we, 1);
            chk("hs_ready", op_ready, 0);
            chk("hs_wdata", mem_wdata, mix[i].exp);
            chk("hs_addr", mem_addr, 32'(4 * i));
            if (i > 0) chk("b2b_wait", w, 1);
        end
        op_valid = 1'b0;
        @(negedge clk);
        chk("mix_done", done, 1);
        chk("mix_count", count, 5);
        chk("mix_hold", {cpu_hold, busy, op_ready}, 0);
        chk("mix_addr", mem_addr, 32'h14);
        chk("mix_nwr", log_a.size() - n, 5);
        for (int i = 0; i < 5; i++) begin
            chk("log_addr", log_a[n + i], 32'(4 * i));
            chk("log_data", log_d[n + i], mix[i].exp);
        end

        // Producer stall with an ignored start pulse in ACCEPT
        pulse(0);
        chk("s2_done_clr", done, 0);
        send(mix[0], 0, w);
        send(mix[1], 0, w);
        op_valid = 1'b0;
        @(negedge clk);
        n = log_a.size();
        for (int c = 0; c < 3; c++) begin
            start = (c == 0);
            @(negedge clk);
            chk("stall_we", mem_we, 0);
            chk("stall_ready", op_ready, 1);
        end
        start = 1'b0;
        chk("stall_nwr", log_a.size() - n, 0);
        chk("stall_count", count, 2);
        chk("stall_addr", mem_addr, 8);
        tmp = mix[2];
        tmp.last = 1'b1;
        send(tmp, 0, w);
        chk("s2_wdata", mem_wdata, 32'h00813503);
        chk("s2_waddr", mem_addr, 8);
        op_valid = 1'b0;
        @(negedge clk);
        chk("s2_done", done, 1);
        chk("s2_count", count, 3);

        // Error cases
        for (int e = 0; e < 3; e++) begin
            pulse(0);
            chk("e_clr", {done, err, err_code}, 0);
            chk("e_addr", mem_addr, 0);
            chk("e_ready", op_ready, 1);
            n = log_a.size();
            send(ev[e], 0, w);
            op_valid = 1'b0;
            chk("e_err", err, 1);
            chk("e_code", err_code, 32'(ecode[e]));
            chk("e_hold", cpu_hold, 1);
            chk("e_busy", {busy, op_ready, mem_we}, 0);
            @(negedge clk);
            chk("e_nwr", log_a.size() - n, 0);
            chk("e_sticky", err, 1);
        end

        // Restart after error, then reset during WRITE
        pulse(0);
        chk("re_clr", {err, err_code}, 0);
        chk("re_addr", mem_addr, 0);
        chk("re_cnt", count, 0);
        send(mix[0], 0, w);
        chk("rw_we", mem_we, 1);
        reset = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("rw_we0", mem_we, 0);
        chk("rw_ready", op_ready, 0);
        chk("rw_count", count, 0);
        chk("rw_hold", {cpu_hold, busy}, 0);
        chk("rw_addr", mem_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Overflow on a 4-word memory
        pulse(1);
        n = slog_a.size();
        for (int i = 0; i < 4; i++) send(mix[0], 1, w);
        op_valid = 1'b0;
        @(negedge clk);
        chk("ov_err", s_err, 1);
        chk("ov_code", s_err_code, 3);
        chk("ov_count", s_count, 4);
        chk("ov_addr", s_mem_addr, 32'hC);
        chk("ov_hold", s_cpu_hold, 1);
        tmp = mix[1];
        tmp.last = 1'b1;
        drive(tmp);
        repeat (3) begin
            @(negedge clk);
            chk("ov_ready", s_op_ready, 0);
            chk("ov_we", s_mem_we, 0);
        end
        op_valid = 1'b0;
        chk("ov_nwr", slog_a.size() - n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("ov_laddr", slog_a[n + i], 32'(4 * i));
            chk("ov_ldata", slog_d[n + i], 32'h002081B3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
Boot-time program loader, the encoding counterpart of the pipeline's opcode decoder. It accepts symbolic instructions (operation kind plus register and immediate fields) over a valid/ready stream. Each one is encoded into a 32-bit RV64 word (add/sub/and/or, ld, sd, beq) and written sequentially into instruction memory. The pipelined core is held off fetch until loading finishes.

Parameters:
ADDR_W, 10, byte-address width of instruction memory; depth = 2^(ADDR_W-2) words
BASE_ADDR, 0, first byte address written; must be a multiple of 4

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a load session
op_valid  in  1  producer has an instruction on op_*
op_ready  out  1  loader accepts this cycle
op_kind  in  3  0 add, 1 sub, 2 and, 3 or, 4 ld, 5 sd, 6 beq, 7 invalid
op_rd  in  5  destination register (R-type, ld)
op_rs1  in  5  source 1
op_rs2  in  5  source 2 (R-type, sd, beq)
op_imm  in  13  signed immediate; byte offset for beq
op_last  in  1  final instruction of the session
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  byte address of the write
mem_wdata  out  32  encoded instruction
cpu_hold  out  1  stall/reset request to the core
busy  out  1  session in progress
done  out  1  session completed cleanly (level)
err  out  1  session aborted (level)
err_code  out  2  01 bad op, 10 bad imm, 11 overflow
count  out  ADDR_W-1  words written this session

Behaviour:
- Reset values: state IDLE, mem_addr=BASE_ADDR, all other outputs 0.
- FSM states: IDLE, ACCEPT, WRITE, DONE, ERR.
- IDLE, DONE, ERR: start -> ACCEPT. Entering ACCEPT this way clears mem_addr to BASE_ADDR, count, done, err and err_code.
- start is ignored in ACCEPT and WRITE.
- ACCEPT: op_ready=1. On op_valid&op_ready, the fields are validated and the encoded word is registered into mem_wdata.
  - Valid fields -> WRITE.
  - op_kind=7 -> ERR, err_code=01.
  - ld/sd with op_imm[12]!=op_imm[11] (outside -2048..2047) -> ERR, err_code=10.
  - beq with op_imm[0]=1 -> ERR, err_code=10.
  - No memory write occurs on any error.
- WRITE: exactly one cycle with mem_we=1, op_ready=0, mem_addr/mem_wdata stable.
  - Next cycle: count+1, mem_addr+4.
  - Then: captured last -> DONE. Else if the write targeted 2^ADDR_W-4 -> ERR, err_code=11 (mem_addr does not wrap). Else -> ACCEPT.
- Timing: handshake at cycle N -> mem_we at N+1 -> op_ready high again at N+2. Maximum throughput is one instruction per 2 cycles.
- cpu_hold=busy=1 in ACCEPT and WRITE. cpu_hold=1 also in ERR. Both are 0 in IDLE and DONE.
- done=1 only in DONE. err=1 only in ERR (sticky until start or reset).
- Encoding:
  - R-type: opcode 0110011, funct3 add/sub 000, and 111, or 110; funct7 0100000 for sub, else 0.
  - ld: opcode 0000011, funct3 011, [31:20]=imm[11:0].
  - sd: opcode 0100011, funct3 011, [31:25]=imm[11:5], [11:7]=imm[4:0].
  - beq: opcode 1100011, funct3 000, [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - Fields unused by a format are ignored: rd for sd/beq, rs2 for ld.
- Reset mid-session: the next cycle is IDLE with mem_we=0 and cpu_hold=0. Memory contents already written are not cleared.

Test Plan:
- Encode mix, BASE_ADDR=0: add x3,x1,x2 -> 0x002081B3 @0x000; sub x5,x6,x7 -> 0x407302B3 @0x004; ld x10,8(x2) -> 0x00813503 @0x008; sd x5,-4(x2) -> 0xFE513E23 @0x00C; beq x1,x2,-8 with last=1 -> 0xFE208CE3 @0x010. Then done=1, count=5, cpu_hold=0.
- Handshake: op_valid held high throughout -> op_ready pattern 1,0,1,0…, exactly one mem_we per accept, no duplicate or dropped words. Producer stalls 3 cycles -> no write during the stall.
- Errors: op_kind=7 -> err_code=01. ld with imm=2048 -> err_code=10. beq with imm=3 -> err_code=10. In each case: no mem_we, err=1, cpu_hold=1; a subsequent start clears the error and restarts at BASE_ADDR.
- Overflow: ADDR_W=4 (4 words), 5 instructions with only the 5th marked last -> 4 writes at 0x0..0xC, then err_code=11, count=4.
- Reset asserted in the WRITE cycle -> following cycle mem_we=0, state IDLE, count=0, op_ready=0.
- start pulsed during ACCEPT -> ignored; count and mem_addr unchanged.
